sprite_frame_sequencer: RTL and testbench

Per-frame controller for the sprite engine peripheral's staging object table. On each frame tick it advances every sprite's position by its velocity and bounces sprites off the logical screen edges. It then streams the updated 32-bit object entries into the staging table, and sets STAGING_READY with a control-register byte write. It owns the peripheral's write port and shares it with a host requester; the host always has priority.

---
 rtl/sprite_frame_sequencer_if.sv | 21 ++
 rtl/sprite_frame_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_sprite_frame_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_frame_sequencer_if.sv
// Peripheral write bus shared between the host requester and the frame
// sequencer. The host side enters as host_*; the arbitrated result leaves
// as address/data_in/data_write_n toward the sprite engine's staging table.
interface sprite_frame_sequencer_if;
  logic [5:0]  host_address;
  logic [31:0] host_data;
  logic [1:0]  host_write_n;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;

  modport master (
    input  host_address, host_data, host_write_n,
    output address, data_in, data_write_n
  );

  modport slave (
    output host_address, host_data, host_write_n,
    input  address, data_in, data_write_n
  );
endinterface

// File: rtl/sprite_frame_sequencer.sv
// Per-frame sprite controller: on a frame tick it moves every sprite by its
// velocity (bouncing off the logical screen edges), streams the updated
// object entries into the staging table and finishes with a control-byte
// write. The host shares the write port and always wins arbitration.
module sprite_frame_sequencer #(
  parameter int unsigned MAX_SPRITES = 2,
  parameter int unsigned SCREEN_W    = 160,
  parameter int unsigned SCREEN_H    = 120,
  localparam int unsigned IDX_W      = (MAX_SPRITES > 1) ? $clog2(MAX_SPRITES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 frame_tick,
  input  logic [7:0]           ctrl_base,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic [7:0]           cfg_x,
  input  logic [7:0]           cfg_y,
  input  logic [3:0]           cfg_vx,
  input  logic [3:0]           cfg_vy,
  input  logic [7:0]           cfg_bitmap,
  input  logic [7:0]           cfg_size,
  sprite_frame_sequencer_if.master bus,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun
);

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_WRITE, S_CTRL} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_SPRITES - 1);
  localparam logic [9:0]       SCR_W    = 10'(SCREEN_W);
  localparam logic [9:0]       SCR_H    = 10'(SCREEN_H);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;
  logic             update_en;
  logic             grant;

  logic [7:0] x_q    [MAX_SPRITES];
  logic [7:0] y_q    [MAX_SPRITES];
  logic [3:0] vx_q   [MAX_SPRITES];
  logic [3:0] vy_q   [MAX_SPRITES];
  logic [7:0] bmp_q  [MAX_SPRITES];
  logic [7:0] size_q [MAX_SPRITES];

  logic [7:0] x_u  [MAX_SPRITES];
  logic [7:0] y_u  [MAX_SPRITES];
  logic [3:0] vx_u [MAX_SPRITES];
  logic [3:0] vy_u [MAX_SPRITES];

  logic [5:0]  req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_wn;

  // One axis of motion: returns {new_pos, new_vel}. Negating -8 saturates to +7.
  function automatic logic [11:0] bounce(input logic [7:0] pos, input logic [3:0] vel,
                                         input logic [3:0] dim_m1, input logic [9:0] screen);
    logic signed [9:0] np;
    logic signed [9:0] lim;
    logic [3:0]        nvel;
    np   = $signed({2'b00, pos}) + $signed({{6{vel[3]}}, vel});
    lim  = $signed(screen - {6'd0, dim_m1} - 10'd1);
    nvel = (vel == 4'b1000) ? 4'b0111 : (~vel + 4'd1);
    if (np < 10'sd0)
      bounce = {8'd0, nvel};
    else if (np > lim)
      bounce = {lim[7:0], nvel};
    else
      bounce = {np[7:0], vel};
  endfunction

  // Candidate next positions/velocities for every sprite, used in UPDATE.
  always_comb begin
    for (int unsigned i = 0; i < MAX_SPRITES; i++) begin
      {x_u[i], vx_u[i]} = bounce(x_q[i], vx_q[i], size_q[i][7:4], SCR_W);
      {y_u[i], vy_u[i]} = bounce(y_q[i], vy_q[i], size_q[i][3:0], SCR_H);
    end
  end

  // Sprite state: a config load for an index overrides that sprite's update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MAX_SPRITES; i++) begin
        x_q[i]    <= '0;
        y_q[i]    <= '0;
        vx_q[i]   <= '0;
        vy_q[i]   <= '0;
        bmp_q[i]  <= '0;
        size_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < MAX_SPRITES; i++) begin
        if (cfg_we && (cfg_idx == IDX_W'(i))) begin
          x_q[i]    <= cfg_x;
          y_q[i]    <= cfg_y;
          vx_q[i]   <= cfg_vx;
          vy_q[i]   <= cfg_vy;
          bmp_q[i]  <= cfg_bitmap;
          size_q[i] <= cfg_size;
        end else if (update_en) begin
          x_q[i]  <= x_u[i];
          y_q[i]  <= y_u[i];
          vx_q[i] <= vx_u[i];
          vy_q[i] <= vy_u[i];
        end
      end
    end
  end

  assign grant = (bus.host_write_n == 2'b11);

  // Sequencer state, entry index and the registered status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state logic and the sequencer's own write request.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    ovr_d     = frame_tick && (state_q != S_IDLE);
    update_en = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    req_wn    = 2'b11;
    case (state_q)
      S_IDLE: begin
        if (frame_tick && enable) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        update_en = 1'b1;
        idx_d     = '0;
        state_d   = S_WRITE;
      end
      S_WRITE: begin
        req_addr = 6'({idx_q, 2'b00});
        req_data = {size_q[idx_q], bmp_q[idx_q], y_q[idx_q], x_q[idx_q]};
        req_wn   = 2'b10;
        if (grant) begin
          if (idx_q == LAST_IDX) state_d = S_CTRL;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      S_CTRL: begin
        req_addr = 6'd63;
        req_data = {24'd0, ctrl_base | 8'h02};
        req_wn   = 2'b00;
        if (grant) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output arbitration: host first; reset forces the port idle immediately.
  always_comb begin
    bus.address      = '0;
    bus.data_in      = '0;
    bus.data_write_n = 2'b11;
    if (!rst_n) begin
      bus.data_write_n = 2'b11;
    end else if (!grant) begin
      bus.address      = bus.host_address;
      bus.data_in      = bus.host_data;
      bus.data_write_n = bus.host_write_n;
    end else begin
      bus.address      = req_addr;
      bus.data_in      = req_data;
      bus.data_write_n = req_wn;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign frame_done = done_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_sprite_frame_sequencer.sv
// Bench for sprite_frame_sequencer: scheduled directed scenarios, a table of
// bounce vectors, and randomized frames scored against a behavioural model.
module tb_sprite_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        frame_tick;
  logic [7:0]  ctrl_base;
  logic        cfg_we;
  logic [0:0]  cfg_idx;
  logic [7:0]  cfg_x, cfg_y, cfg_bitmap, cfg_size;
  logic [3:0]  cfg_vx, cfg_vy;
  logic        busy, frame_done, overrun;

  sprite_frame_sequencer_if bus();

  sprite_frame_sequencer #(
    .MAX_SPRITES(2),
    .SCREEN_W(160),
    .SCREEN_H(120)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_tick(frame_tick),
    .ctrl_base(ctrl_base), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_vx(cfg_vx), .cfg_vy(cfg_vy),
    .cfg_bitmap(cfg_bitmap), .cfg_size(cfg_size), .bus(bus.master),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        tick, en, rst_n, cfg_we;
    logic [0:0]  cfg_idx;
    logic [7:0]  cx, cy, cbmp, csz, cb;
    logic [3:0]  cvx, cvy;
    logic [1:0]  hwn;
    logic [5:0]  haddr;
    logic [31:0] hdata;
  } stim_t;

  typedef struct {
    logic [7:0]  x, y;
    logic [3:0]  vx, vy;
    logic [7:0]  bmp, sz;
    logic [31:0] e1, e2;
  } tv_t;

  stim_t       st     [24];
  logic [5:0]  r_addr [24];
  logic [31:0] r_data [24];
  logic [1:0]  r_wn   [24];
  logic        r_busy [24];
  logic        r_done [24];
  logic        r_ovr  [24];

  function automatic stim_t dflt();
    stim_t s;
    s.tick = 1'b0; s.en = 1'b1; s.rst_n = 1'b1; s.cfg_we = 1'b0; s.cfg_idx = '0;
    s.cx = '0; s.cy = '0; s.cbmp = '0; s.csz = '0; s.cb = '0; s.cvx = '0; s.cvy = '0;
    s.hwn = 2'b11; s.haddr = '0; s.hdata = '0;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    rst_n = s.rst_n; frame_tick = s.tick; enable = s.en; ctrl_base = s.cb;
    cfg_we = s.cfg_we; cfg_idx = s.cfg_idx; cfg_x = s.cx; cfg_y = s.cy;
    cfg_vx = s.cvx; cfg_vy = s.cvy; cfg_bitmap = s.cbmp; cfg_size = s.csz;
    bus.host_write_n = s.hwn; bus.host_address = s.haddr; bus.host_data = s.hdata;
  endtask

  task automatic clear();
    for (int i = 0; i < 24; i++) st[i] = dflt();
  endtask

  task automatic set_cfg(input int k, input logic [0:0] idx, input logic [7:0] x, input logic [7:0] y,
                         input logic [3:0] vx, input logic [3:0] vy, input logic [7:0] bmp, input logic [7:0] sz);
    st[k].cfg_we = 1'b1; st[k].cfg_idx = idx; st[k].cx = x; st[k].cy = y;
    st[k].cvx = vx; st[k].cvy = vy; st[k].cbmp = bmp; st[k].csz = sz;
  endtask

  // Called at posedge+1: cycle k starts with st[k] applied, outputs sampled at negedge.
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      apply(st[k]);
      @(negedge clk);
      r_addr[k] = bus.address; r_data[k] = bus.data_in; r_wn[k] = bus.data_write_n;
      r_busy[k] = busy; r_done[k] = frame_done; r_ovr[k] = overrun;
      @(posedge clk); #1;
    end
    apply(dflt());
  endtask

  // Behavioural model state for the randomized frames.
  int         mx [2], my [2], mvx [2], mvy [2];
  logic [7:0] msz [2], mbmp [2];
  logic [39:0] expq [$];

  function automatic int sx4(input logic [3:0] v);
    return v[3] ? int'(v) - 16 : int'(v);
  endfunction

  function automatic int negs(input int v);
    return (v == -8) ? 7 : -v;
  endfunction

  task automatic axis(inout int p, inout int v, input int lim);
    int np;
    np = p + v;
    if (np < 0)        begin p = 0;   v = negs(v); end
    else if (np > lim) begin p = lim; v = negs(v); end
    else               p = np;
  endtask

  task automatic model_frame(input logic [7:0] cb);
    for (int s = 0; s < 2; s++) begin
      axis(mx[s], mvx[s], 160 - (int'(msz[s][7:4]) + 1));
      axis(my[s], mvy[s], 120 - (int'(msz[s][3:0]) + 1));
      expq.push_back({6'(4 * s), msz[s], mbmp[s], 8'(my[s]), 8'(mx[s]), 2'b10});
    end
    expq.push_back({6'd63, 24'd0, cb | 8'h02, 2'b00});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tv_t tv [7];
    int  cnt_w, cnt_o, cnt_d, cnt_b;
    tv[0] = '{8'd10,  8'd20,  4'd3, 4'hE, 8'h00, 8'h33, 32'h3300120D, 32'h33001010};
    tv[1] = '{8'd155, 8'd20,  4'd3, 4'd0, 8'h05, 8'h33, 32'h3305149C, 32'h33051499};
    tv[2] = '{8'd1,   8'd0,   4'hC, 4'd0, 8'h11, 8'h00, 32'h00110000, 32'h00110004};
    tv[3] = '{8'd0,   8'd115, 4'd0, 4'd7, 8'hAA, 8'h07, 32'h07AA7000, 32'h07AA6900};
    tv[4] = '{8'd144, 8'd5,   4'd6, 4'hB, 8'h01, 8'h93, 32'h93010096, 32'h93010096};
    tv[5] = '{8'd255, 8'd200, 4'd0, 4'd0, 8'h00, 8'h00, 32'h0000779F, 32'h0000779F};
    tv[6] = '{8'd3,   8'd10,  4'h8, 4'd0, 8'h00, 8'h00, 32'h00000A00, 32'h00000A07};

    apply(dflt());
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_wn", bus.data_write_n, 2'b11);
    chk("reset_addr", bus.address, 6'd0);
    chk("reset_data", bus.data_in, 32'd0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", frame_done, 1'b0);
    chk("reset_ovr", overrun, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic latency: cfg at c0, tick at c1 -> UPDATE c2, W0 c3, W1 c4, CTRL c5, done c6.
    clear();
    set_cfg(0, 1'b0, 8'd10, 8'd20, 4'd3, 4'hE, 8'h00, 8'h33);
    st[1].tick = 1'b1;
    run(9);
    chk("lat_idle_busy", r_busy[1], 1'b0);
    chk("lat_update", {r_busy[2], r_wn[2]}, {1'b1, 2'b11});
    chk("lat_w0", {r_addr[3], r_data[3], r_wn[3]}, {6'd0, 32'h3300120D, 2'b10});
    chk("lat_w1", {r_addr[4], r_data[4], r_wn[4]}, {6'd4, 32'h00000000, 2'b10});
    chk("lat_ctrl", {r_addr[5], r_data[5], r_wn[5]}, {6'd63, 32'h00000002, 2'b00});
    chk("lat_ctrl_busy", r_busy[5], 1'b1);
    chk("lat_done", {r_done[5], r_done[6], r_done[7], r_busy[6]}, 4'b0100);

    // Bounce table: two frames per vector, entry 0 checked both times.
    for (int t = 0; t < 7; t++) begin
      clear();
      set_cfg(0, 1'b0, tv[t].x, tv[t].y, tv[t].vx, tv[t].vy, tv[t].bmp, tv[t].sz);
      st[1].tick = 1'b1;
      st[8].tick = 1'b1;
      st[8].cb   = 8'hA5;
      st[9]      = st[8];
      st[9].tick = 1'b0;
      for (int k = 10; k < 14; k++) st[k].cb = 8'hA5;
      run(14);
      chk($sformatf("tv%0d_w0_slot", t), {r_addr[3], r_wn[3]}, {6'd0, 2'b10});
      chk($sformatf("tv%0d_frame1", t), r_data[3], tv[t].e1);
      chk($sformatf("tv%0d_frame2", t), r_data[10], tv[t].e2);
      chk($sformatf("tv%0d_ctrl2", t), {r_addr[12], r_data[12], r_wn[12]}, {6'd63, 32'h000000A7, 2'b00});
    end

    // Host collision: host write held in c2..c3 stalls the sequence by two cycles.
    clear();
    st[0].tick = 1'b1;
    for (int k = 2; k < 4; k++) begin
      st[k].hwn = 2'b00; st[k].haddr = 6'd8; st[k].hdata = 32'hDEADBEEF;
    end
    run(10);
    chk("host_c2", {r_addr[2], r_data[2], r_wn[2]}, {6'd8, 32'hDEADBEEF, 2'b00});
    chk("host_c3", {r_addr[3], r_data[3], r_wn[3]}, {6'd8, 32'hDEADBEEF, 2'b00});
    chk("host_w0", {r_addr[4], r_wn[4]}, {6'd0, 2'b10});
    chk("host_w1", {r_addr[5], r_wn[5]}, {6'd4, 2'b10});
    chk("host_ctrl", {r_addr[6], r_wn[6]}, {6'd63, 2'b00});
    chk("host_done", {r_done[6], r_done[7]}, 2'b01);

    // Overrun: second tick in c3 is dropped, flagged in c4.
    clear();
    st[0].tick = 1'b1;
    st[3].tick = 1'b1;
    run(12);
    cnt_w = 0; cnt_o = 0; cnt_d = 0;
    for (int k = 0; k < 12; k++) begin
      if (r_wn[k] != 2'b11) cnt_w++;
      if (r_ovr[k]) cnt_o++;
      if (r_done[k]) cnt_d++;
    end
    chk("ovr_c4", r_ovr[4], 1'b1);
    chk("ovr_pulses", cnt_o, 1);
    chk("ovr_writes", cnt_w, 3);
    chk("ovr_frames", cnt_d, 1);

    // Disabled tick is ignored entirely.
    clear();
    st[0].tick = 1'b1;
    st[0].en   = 1'b0;
    run(6);
    cnt_w = 0; cnt_o = 0; cnt_b = 0;
    for (int k = 0; k < 6; k++) begin
      if (r_wn[k] != 2'b11) cnt_w++;
      if (r_ovr[k]) cnt_o++;
      if (r_busy[k]) cnt_b++;
    end
    chk("dis_writes", cnt_w, 0);
    chk("dis_ovr", cnt_o, 0);
    chk("dis_busy", cnt_b, 0);

    // cfg during UPDATE wins for that sprite; cfg before WRITE(1) shows up in it.
    clear();
    set_cfg(0, 1'b0, 8'd10, 8'd20, 4'd1, 4'd1, 8'h00, 8'h00);
    st[2].tick = 1'b1;
    set_cfg(3, 1'b0, 8'd50, 8'd60, 4'd0, 4'd0, 8'h44, 8'h11);
    set_cfg(4, 1'b1, 8'h21, 8'h22, 4'd0, 4'd0, 8'h23, 8'h24);
    run(10);
    chk("cfg_upd_w0", {r_addr[4], r_data[4]}, {6'd0, 32'h11443C32});
    chk("cfg_pre_w1", {r_addr[5], r_data[5]}, {6'd4, 32'h24232221});

    // Reset mid-sequence: port idles at once and no control write follows.
    clear();
    st[0].tick  = 1'b1;
    st[3].rst_n = 1'b0;
    st[4].rst_n = 1'b0;
    run(10);
    chk("rst_w0_before", r_wn[2], 2'b10);
    chk("rst_c3", {r_wn[3], r_busy[3]}, {2'b11, 1'b0});
    cnt_w = 0; cnt_d = 0;
    for (int k = 3; k < 10; k++) begin
      if (r_wn[k] != 2'b11) cnt_w++;
      if (r_done[k]) cnt_d++;
    end
    chk("rst_no_writes", cnt_w, 0);
    chk("rst_no_done", cnt_d, 0);

    // Randomized frames with random host traffic against the model.
    for (int c = 0; c < 8; c++) begin
      for (int s = 0; s < 2; s++) begin
        cfg_we = 1'b1; cfg_idx = 1'(s);
        cfg_x = 8'($urandom); cfg_y = 8'($urandom);
        cfg_vx = 4'($urandom); cfg_vy = 4'($urandom);
        cfg_bitmap = 8'($urandom); cfg_size = 8'($urandom);
        mx[s] = int'(cfg_x); my[s] = int'(cfg_y);
        mvx[s] = sx4(cfg_vx); mvy[s] = sx4(cfg_vy);
        mbmp[s] = cfg_bitmap; msz[s] = cfg_size;
        @(posedge clk); #1;
      end
      cfg_we = 1'b0;
      for (int f = 0; f < 4; f++) begin
        logic seen;
        logic [7:0] cb;
        cb = 8'($urandom);
        ctrl_base = cb;
        model_frame(cb);
        frame_tick = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
          @(negedge clk);
          if (bus.host_write_n != 2'b11) begin
            chk("rnd_host_pass", {bus.address, bus.data_in, bus.data_write_n},
                {bus.host_address, bus.host_data, bus.host_write_n});
          end else if (bus.data_write_n != 2'b11) begin
            if (expq.size() == 0) begin
              n_cmp++; n_bad++;
              $display("FAIL rnd_unexpected_write: got 0x%0h expected no write",
                       {bus.address, bus.data_in, bus.data_write_n});
            end else begin
              chk("rnd_frame_write", {bus.address, bus.data_in, bus.data_write_n}, expq.pop_front());
            end
          end
          if (frame_done) seen = 1'b1;
          @(posedge clk); #1;
          frame_tick = 1'b0;
          if ($urandom_range(0, 9) < 3) begin
            bus.host_write_n = 2'($urandom_range(0, 2));
            bus.host_address = 6'($urandom);
            bus.host_data    = $urandom;
          end else begin
            bus.host_write_n = 2'b11;
          end
        end
        bus.host_write_n = 2'b11;
        chk("rnd_frame_done", seen, 1'b1);
        chk("rnd_queue_drained", expq.size(), 0);
        expq.delete();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
